// File: rtl/sram_mem_ctrl_if.sv
// Core-side request/response and SRAM-side bus of the multi-cycle data-memory controller.
// The slave modport is the controller. The master modport is the core plus the SRAM around it.
interface sram_mem_ctrl_if #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int SRAM_DATA_W = 16,
   parameter int SRAM_ADDR_W = 18
);
   // Handshake: the core raises rd_en or wr_en and holds them, address and
   // write_data stable. ready=0 while an access is in flight. The access is
   // complete in the cycle where ready=1 with a request pending, and the core
   // advances on that clock edge.
   logic                   rd_en;
   logic                   wr_en;
   logic [ADDR_W-1:0]      address;
   logic [DATA_W-1:0]      write_data;
   logic [DATA_W-1:0]      read_data;
   logic                   ready;
   logic [SRAM_ADDR_W-1:0] sram_addr;
   logic [SRAM_DATA_W-1:0] sram_dq_o;
   logic [SRAM_DATA_W-1:0] sram_dq_i;
   logic                   sram_dq_oe;
   logic                   sram_we_n;

   modport slave (
      input  rd_en, wr_en, address, write_data, sram_dq_i,
      output read_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
   );

   modport master (
      output rd_en, wr_en, address, write_data, sram_dq_i,
      input  read_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller. Each core word becomes two fixed-wait SRAM
// half-accesses, low half first. ready is held low while an access is in flight.
module sram_mem_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int SRAM_DATA_W = 16,
   parameter int SRAM_ADDR_W = 18,
   parameter int WAIT_CYCLES = 5,
   parameter int BASE_ADDR   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   sram_mem_ctrl_if.slave bus,
   output logic [1:0]  dbg_state
);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int HALF  = SRAM_DATA_W;

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic                   wr_q;
   logic                   req;
   logic                   last_cyc;
   logic [ADDR_W-1:0]      offset;
   logic [SRAM_ADDR_W-2:0] word;

   assign req      = bus.rd_en | bus.wr_en;
   assign last_cyc = (cnt == CNT_W'(WAIT_CYCLES - 1));
   // Out-of-range addresses wrap silently into the SRAM word space.
   assign offset   = bus.address - ADDR_W'(BASE_ADDR);
   assign word     = offset[2 +: SRAM_ADDR_W-1];
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req) state_nxt = S_LO;
         S_LO:    if (last_cyc) state_nxt = S_HI;
         S_HI:    if (last_cyc) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ready      = 1'b0;
      bus.sram_we_n  = 1'b1;
      bus.sram_dq_oe = 1'b0;
      case (state)
         S_IDLE:     bus.ready = ~req;
         S_LO, S_HI: begin
            bus.sram_we_n  = ~wr_q;
            bus.sram_dq_oe = wr_q;
         end
         S_DONE:     bus.ready = 1'b1;
         default:    ;
      endcase
   end

   // The access kind and low address are captured at start. A request dropped mid-access still finishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         wr_q          <= 1'b0;
         bus.read_data <= '0;
         bus.sram_addr <= '0;
         bus.sram_dq_o <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  cnt           <= '0;
                  wr_q          <= bus.wr_en;
                  bus.sram_addr <= {word, 1'b0};
                  if (bus.wr_en) bus.sram_dq_o <= bus.write_data[HALF-1:0];
               end
            end
            S_LO: begin
               if (last_cyc) begin
                  cnt           <= '0;
                  bus.sram_addr <= {bus.sram_addr[SRAM_ADDR_W-1:1], 1'b1};
                  if (wr_q) bus.sram_dq_o <= bus.write_data[DATA_W-1:HALF];
                  else      bus.read_data[HALF-1:0] <= bus.sram_dq_i;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_HI: begin
               if (last_cyc) begin
                  cnt <= '0;
                  if (!wr_q) bus.read_data[DATA_W-1:HALF] <= bus.sram_dq_i;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: directed spec scenarios then randomized accesses,
// compared against a word-level memory model and an expected read queue.
module tb_sram_mem_ctrl;
   localparam int W    = 5;
   localparam int BASE = 1024;
   localparam int LAT  = 2 * W + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] dbg_state;

   sram_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32), .SRAM_DATA_W(16), .SRAM_ADDR_W(18)) bus ();

   sram_mem_ctrl #(
      .DATA_W(32), .ADDR_W(32), .SRAM_DATA_W(16), .SRAM_ADDR_W(18),
      .WAIT_CYCLES(W), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // External SRAM: asynchronous read, write on the clock edge while we_n is low.
   logic [15:0] sram_mem [0:(1<<18)-1];
   logic        pre_en = 1'b0;
   logic [16:0] pre_word = '0;
   logic [31:0] pre_data = '0;
   assign bus.sram_dq_i = sram_mem[bus.sram_addr];
   always @(posedge clk) begin
      if (pre_en) begin
         sram_mem[{pre_word, 1'b0}] <= pre_data[15:0];
         sram_mem[{pre_word, 1'b1}] <= pre_data[31:16];
      end else if (!bus.sram_we_n) begin
         sram_mem[bus.sram_addr] <= bus.sram_dq_o;
      end
   end

   int cycle_cnt = 0;
   always @(posedge clk) cycle_cnt++;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] ref_mem [int];
   logic [31:0] exp_q [$];
   logic [31:0] last_read = '0;
   int          done_cycle = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int word_of(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - 32'(BASE);
      return int'((off >> 2) & 32'h1FFFF);
   endfunction

   function automatic logic [31:0] ref_read(input int word);
      if (ref_mem.exists(word)) return ref_mem[word];
      return 32'h0;
   endfunction

   task automatic preload(input int word, input logic [31:0] d);
      logic [31:0] w;
      w        = word;
      pre_en   = 1'b1;
      pre_word = w[16:0];
      pre_data = d;
      @(posedge clk); #1;
      pre_en = 1'b0;
      ref_mem[word] = d;
   endtask

   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data);
      int          cyc;
      int          we_low;
      int          word;
      bit          done;
      logic [17:0] lo_addr;
      logic [17:0] hi_addr;
      logic [15:0] lo_dq;
      logic [15:0] hi_dq;
      logic [31:0] rd_at_done;
      logic [31:0] exp;
      word = word_of(addr);
      if (!wr) exp_q.push_back(ref_read(word));
      bus.rd_en = rd; bus.wr_en = wr; bus.address = addr; bus.write_data = data;
      cyc = 0; we_low = 0; done = 1'b0;
      lo_addr = '0; hi_addr = '0; lo_dq = '0; hi_dq = '0; rd_at_done = '0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         if (!bus.sram_we_n) we_low++;
         if (cyc == 1)     begin lo_addr = bus.sram_addr; lo_dq = bus.sram_dq_o; end
         if (cyc == W + 1) begin hi_addr = bus.sram_addr; hi_dq = bus.sram_dq_o; end
         if (bus.ready) begin
            done = 1'b1; rd_at_done = bus.read_data; done_cycle = cycle_cnt;
         end else begin
            cyc++;
         end
         @(posedge clk); #1;
      end
      bus.rd_en = 1'b0; bus.wr_en = 1'b0;
      check("latency", 64'(cyc), 64'(LAT));
      check("lo_addr", 64'(lo_addr), 64'(word * 2));
      check("hi_addr", 64'(hi_addr), 64'(word * 2 + 1));
      if (wr) begin
         check("we_low_cycles", 64'(we_low), 64'(2 * W));
         check("dq_lo", 64'(lo_dq), 64'(data[15:0]));
         check("dq_hi", 64'(hi_dq), 64'(data[31:16]));
         check("read_data_kept", 64'(rd_at_done), 64'(last_read));
         ref_mem[word] = data;
      end else begin
         exp = exp_q.pop_front();
         check("we_low_cycles", 64'(we_low), 64'(0));
         check("read_data", 64'(rd_at_done), 64'(exp));
         last_read = exp;
      end
   endtask

   initial begin
      int          first_done;
      int          k;
      int          op;
      logic [31:0] addr;
      bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 64'(bus.ready), 64'(1));
      check("rst_read_data", 64'(bus.read_data), 64'(0));
      check("rst_we_n", 64'(bus.sram_we_n), 64'(1));
      check("rst_dq_oe", 64'(bus.sram_dq_oe), 64'(0));
      check("rst_sram_addr", 64'(bus.sram_addr), 64'(0));
      check("rst_sram_dq_o", 64'(bus.sram_dq_o), 64'(0));
      @(posedge clk); #1;

      // Read of two preloaded halves
      preload(0, 32'hDEADBEEF);
      do_access(1'b1, 1'b0, 32'd1024, 32'h0);

      // Write, inspect SRAM halves, read back
      do_access(1'b0, 1'b1, 32'd1028, 32'h12345678);
      check("sram2", 64'(sram_mem[2]), 64'(16'h5678));
      check("sram3", 64'(sram_mem[3]), 64'(16'h1234));
      do_access(1'b1, 1'b0, 32'd1028, 32'h0);

      // Read and write together: the write wins
      do_access(1'b1, 1'b1, 32'd1032, 32'hA5A50F0F);
      check("both_sram4", 64'(sram_mem[4]), 64'(16'h0F0F));
      check("both_sram5", 64'(sram_mem[5]), 64'(16'hA5A5));

      // Two reads held back to back
      do_access(1'b1, 1'b0, 32'd1024, 32'h0);
      first_done = done_cycle;
      do_access(1'b1, 1'b0, 32'd1028, 32'h0);
      check("b2b_gap", 64'(done_cycle - first_done), 64'(12));

      // Address below the base wraps to the top word
      preload(131071, 32'h0BADCAFE);
      do_access(1'b1, 1'b0, 32'd1020, 32'h0);

      // Reset in the third HI cycle of a write
      bus.wr_en = 1'b1; bus.address = 32'd2048; bus.write_data = 32'hCAFEF00D;
      repeat (8) begin @(posedge clk); #1; end
      @(negedge clk);
      check("mid_we_n", 64'(bus.sram_we_n), 64'(0));
      rst = 1'b1; bus.wr_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready", 64'(bus.ready), 64'(1));
      check("abort_we_n", 64'(bus.sram_we_n), 64'(1));
      check("abort_dq_oe", 64'(bus.sram_dq_oe), 64'(0));
      check("abort_read_data", 64'(bus.read_data), 64'(0));
      last_read = '0;
      @(posedge clk); #1;

      // Randomized mix over a small word set so reads hit earlier writes
      for (int i = 0; i < 16; i++) preload(i, $urandom);
      for (int i = 0; i < 24; i++) begin
         k    = $urandom_range(0, 16);
         addr = (k == 16) ? 32'd1020 : 32'(BASE + 4 * k);
         op   = $urandom_range(0, 3);
         do_access(op != 1, (op == 1) || (op == 2), addr, $urandom);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      check("exp_q_empty", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
